cam_axis_packer: RTL and testbench

Parametrised CameraLink-to-AXI4-Stream video packer that generalises the single-tap-set capture path to 1-3 taps of 8-16 bits, with an in-block line FIFO, frame resynchronisation, overflow drop-to-next-frame and line-length checking. It sits after the parser/CDC stage, so its pixel input is already in the `aclk` domain. Its AXIS master feeds the video DMA.

---
 rtl/cam_axis_packer_if.sv | 14 +
 rtl/cam_axis_packer.sv | 242 ++++++++++++++++++++++++
 tb/tb_cam_axis_packer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_axis_packer_if.sv
// AXI4-Stream video link from the packer to the video DMA.
interface cam_axis_packer_if #(
    parameter int DATA_WIDTH = 24
) ();
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic                    tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/cam_axis_packer.sv
// CameraLink pixel taps to AXI4-Stream packer with line FIFO, frame resync,
// overflow drop-to-next-frame and line-length checking.
//
// state        | meaning
// S_WAIT_FRAME | idle, waiting for a frame-valid rising edge
// S_ACTIVE     | capturing pixels of the current frame
// S_DROP       | frame aborted by overflow, discarding until next frame
module cam_axis_packer #(
    parameter int PIX_WIDTH   = 8,
    parameter int NUM_TAPS    = 3,
    parameter int DATA_WIDTH  = ((NUM_TAPS*PIX_WIDTH+7)/8)*8,
    parameter int FIFO_DEPTH  = 1024,
    parameter int RGB_REORDER = 1
) (
    input  logic                          aclk,
    input  logic                          rst,
    input  logic [NUM_TAPS*PIX_WIDTH-1:0] pix_data,
    input  logic                          pix_dval,
    input  logic                          pix_lval,
    input  logic                          pix_fval,
    input  logic [15:0]                   cfg_line_len,
    cam_axis_packer_if.master             m_axis,
    output logic                          overflow,
    output logic                          err_line_len,
    output logic                          frame_active,
    output logic [15:0]                   frame_count,
    output logic [15:0]                   drop_count
);
    localparam int IN_W = NUM_TAPS*PIX_WIDTH;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int WW   = DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        S_WAIT_FRAME = 2'd0,
        S_ACTIVE     = 2'd1,
        S_DROP       = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_fval_q;
    logic                  r_lval_q;
    logic                  w_fval_rise;
    logic                  w_fval_fall;
    logic                  w_lval_fall;
    logic                  w_start;
    logic                  w_frame_done;
    logic                  w_accept;
    logic [IN_W-1:0]       w_pix_ord;
    logic [DATA_WIDTH-1:0] w_pix_pad;

    logic                  r_pend_vld;
    logic                  r_pend_sof;
    logic [DATA_WIDTH-1:0] r_pend_data;
    logic                  r_sof_pend;
    logic [15:0]           r_line_cnt;

    logic                  w_eol_push;
    logic                  w_push;
    logic                  w_push_ok;
    logic                  w_ovf;
    logic                  w_len_err;
    logic [WW-1:0]         w_push_word;

    logic [WW-1:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_mem_cnt;
    logic [AW:0]           w_total;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_load_out;
    logic                  r_out_vld;
    logic [WW-1:0]         r_out_word;

    logic                  r_overflow;
    logic                  r_err_line_len;
    logic [15:0]           r_frame_count;
    logic [15:0]           r_drop_count;

    assign w_fval_rise = pix_fval & ~r_fval_q;
    assign w_fval_fall = ~pix_fval & r_fval_q;
    assign w_lval_fall = ~pix_lval & r_lval_q;
    assign w_accept    = pix_dval & pix_lval & pix_fval & (r_state == S_ACTIVE);

    // Tap C lands in the MSBs; with RGB reordering tap A moves to the middle.
    generate
        if (NUM_TAPS == 3 && RGB_REORDER != 0) begin : g_rgb
            assign w_pix_ord = {pix_data[3*PIX_WIDTH-1:2*PIX_WIDTH],
                                pix_data[PIX_WIDTH-1:0],
                                pix_data[2*PIX_WIDTH-1:PIX_WIDTH]};
        end else begin : g_pass
            assign w_pix_ord = pix_data;
        end
    endgenerate
    assign w_pix_pad = DATA_WIDTH'(w_pix_ord);

    // Accept and line/frame end are exclusive, so at most one push per cycle.
    assign w_eol_push  = (w_lval_fall | w_fval_fall) & r_pend_vld;
    assign w_push      = w_eol_push | (w_accept & r_pend_vld);
    assign w_push_word = {r_pend_sof, w_eol_push, r_pend_data};

    // Occupancy includes the output register, so full means FIFO_DEPTH words held.
    assign w_total    = r_mem_cnt + {{AW{1'b0}}, r_out_vld};
    assign w_full     = (w_total == (AW+1)'(FIFO_DEPTH));
    assign w_pop      = r_out_vld & m_axis.tready;
    assign w_ovf      = w_push & w_full & ~w_pop;
    assign w_push_ok  = w_push & ~w_ovf;
    assign w_load_out = (r_mem_cnt != '0) & (~r_out_vld | w_pop);

    assign w_len_err = w_push_ok & w_eol_push & (cfg_line_len != 16'd0) &
                       (({1'b0, r_line_cnt} + 17'd1) != {1'b0, cfg_line_len});

    // Timing-bit history for edge detection; fval history starts high.
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_fval_q <= 1'b1;
            r_lval_q <= 1'b0;
        end else begin
            r_fval_q <= pix_fval;
            r_lval_q <= pix_lval;
        end
    end

    // Frame state register.
    always_ff @(posedge aclk) begin
        if (rst) r_state <= S_WAIT_FRAME;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode; overflow wins over a coincident frame end.
    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_WAIT_FRAME, S_DROP: begin
                if (w_fval_rise) begin
                    w_state_nxt = S_ACTIVE;
                    w_start     = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_ovf) begin
                    w_state_nxt = S_DROP;
                end else if (w_fval_fall) begin
                    w_state_nxt  = S_WAIT_FRAME;
                    w_frame_done = 1'b1;
                end
            end
            default: w_state_nxt = S_WAIT_FRAME;
        endcase
    end

    // One-entry pending register holds a beat until we know whether it ends the line.
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_pend_vld  <= 1'b0;
            r_pend_sof  <= 1'b0;
            r_pend_data <= '0;
            r_sof_pend  <= 1'b0;
        end else begin
            if (w_start) r_sof_pend <= 1'b1;
            if (w_ovf) begin
                r_pend_vld <= 1'b0;
                r_sof_pend <= 1'b0;
            end else if (w_accept) begin
                r_pend_vld  <= 1'b1;
                r_pend_data <= w_pix_pad;
                r_pend_sof  <= r_sof_pend;
                r_sof_pend  <= 1'b0;
            end else if (w_eol_push) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    // Beats pushed in the current line, saturating.
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_line_cnt <= '0;
        end else if (w_start) begin
            r_line_cnt <= '0;
        end else if (w_push_ok) begin
            if (w_eol_push)                r_line_cnt <= '0;
            else if (r_line_cnt != 16'hFFFF) r_line_cnt <= r_line_cnt + 16'd1;
        end
    end

    // FIFO storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge aclk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_push_word;
    end

    // FIFO pointers and the registered head word that drives the AXIS outputs.
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_out_vld  <= 1'b0;
            r_out_word <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            r_mem_cnt <= r_mem_cnt + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_load_out};
            if (w_load_out) begin
                r_out_word <= r_mem[r_rd_ptr];
                r_out_vld  <= 1'b1;
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end else if (w_pop) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    // Status pulses and frame counters.
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_overflow     <= 1'b0;
            r_err_line_len <= 1'b0;
            r_frame_count  <= '0;
            r_drop_count   <= '0;
        end else begin
            r_overflow     <= w_ovf;
            r_err_line_len <= w_len_err;
            if (w_frame_done) r_frame_count <= r_frame_count + 16'd1;
            if (w_ovf && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign m_axis.tvalid = r_out_vld;
    assign m_axis.tdata  = r_out_word[DATA_WIDTH-1:0];
    assign m_axis.tlast  = r_out_word[DATA_WIDTH];
    assign m_axis.tuser  = r_out_word[DATA_WIDTH+1];
    assign m_axis.tkeep  = '1;

    assign overflow     = r_overflow;
    assign err_line_len = r_err_line_len;
    assign frame_active = (r_state == S_ACTIVE);
    assign frame_count  = r_frame_count;
    assign drop_count   = r_drop_count;
endmodule

// File: tb/tb_cam_axis_packer.sv
// Scoreboard bench for cam_axis_packer: a 3-tap RGB instance with a 4-deep
// FIFO, plus a 1-tap 10-bit instance for the zero-padding path.
module tb_cam_axis_packer;
    logic        aclk = 1'b0;
    logic        rst;
    logic [23:0] pix_data;
    logic [9:0]  pix_data2;
    logic        pix_dval, pix_lval, pix_fval;
    logic [15:0] cfg_line_len;
    logic        tready = 1'b1;
    logic        rdy_level;
    logic        bp_mode;

    logic        overflow0, err_line_len0, frame_active0;
    logic [15:0] frame_count0, drop_count0;
    logic        overflow1, err_line_len1, frame_active1;
    logic [15:0] frame_count1, drop_count1;

    always #5 aclk = ~aclk;

    cam_axis_packer_if #(.DATA_WIDTH(24)) axis0 ();
    cam_axis_packer_if #(.DATA_WIDTH(16)) axis1 ();
    assign axis0.tready = tready;
    assign axis1.tready = 1'b1;

    cam_axis_packer #(.PIX_WIDTH(8), .NUM_TAPS(3), .DATA_WIDTH(24),
                      .FIFO_DEPTH(4), .RGB_REORDER(1)) dut0 (
        .aclk(aclk), .rst(rst), .pix_data(pix_data), .pix_dval(pix_dval),
        .pix_lval(pix_lval), .pix_fval(pix_fval), .cfg_line_len(cfg_line_len),
        .m_axis(axis0), .overflow(overflow0), .err_line_len(err_line_len0),
        .frame_active(frame_active0), .frame_count(frame_count0), .drop_count(drop_count0));

    cam_axis_packer #(.PIX_WIDTH(10), .NUM_TAPS(1), .DATA_WIDTH(16),
                      .FIFO_DEPTH(8), .RGB_REORDER(1)) dut1 (
        .aclk(aclk), .rst(rst), .pix_data(pix_data2), .pix_dval(pix_dval),
        .pix_lval(pix_lval), .pix_fval(pix_fval), .cfg_line_len(cfg_line_len),
        .m_axis(axis1), .overflow(overflow1), .err_line_len(err_line_len1),
        .frame_active(frame_active1), .frame_count(frame_count1), .drop_count(drop_count1));

    int          chk_cnt = 0;
    int          err_cnt = 0;
    logic [25:0] exp_q[$];
    bit          sof_next;
    int          seq;
    int          ovf_pulses = 0;
    int          err_pulses = 0;
    int          beats_seen = 0;
    int          pad_beats  = 0;
    logic [23:0] last_tdata;
    bit          hold_pend = 1'b0;
    logic [25:0] hold_word;
    logic [25:0] w0;
    logic [25:0] e0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // sole driver of tready: steady level or 1-0-1-0 toggling
    always begin
        @(posedge aclk);
        #1;
        if (bp_mode) tready = ~tready;
        else         tready = rdy_level;
    end

    // scoreboard, hold-stability and pulse monitor for the RGB instance
    always @(negedge aclk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            w0 = {axis0.tuser, axis0.tlast, axis0.tdata};
            if (hold_pend) begin
                check("hold_tvalid", 32'(axis0.tvalid), 32'd1);
                check("hold_word", 32'(w0), 32'(hold_word));
            end
            if (axis0.tvalid && axis0.tready) begin
                beats_seen++;
                last_tdata = axis0.tdata;
                check("tkeep", 32'(axis0.tkeep), 32'h7);
                check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e0 = exp_q.pop_front();
                    check("beat_word", 32'(w0), 32'(e0));
                end
            end
            hold_pend = axis0.tvalid && !axis0.tready;
            hold_word = w0;
            if (overflow0)     ovf_pulses++;
            if (err_line_len0) err_pulses++;
        end
    end

    // padding monitor for the 1-tap 10-bit instance
    always @(negedge aclk) begin
        if (!rst && axis1.tvalid) begin
            pad_beats++;
            check("pad_tdata", 32'(axis1.tdata), 32'h03FF);
            check("pad_tkeep", 32'(axis1.tkeep), 32'h3);
        end
    end

    task automatic drive_pixel(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                               input bit eol, input bit exp_en);
        pix_data = {c, b, a};
        pix_dval = 1'b1;
        pix_lval = 1'b1;
        if (exp_en) begin
            exp_q.push_back({sof_next, eol, c, a, b});
            sof_next = 1'b0;
        end
        step();
    endtask

    task automatic drive_line(input int n, input int n_exp, input int gap, input bit hole);
        for (int i = 0; i < n; i++) begin
            if (hole && i == 2) begin
                pix_dval = 1'b0;
                step();
            end
            drive_pixel(8'(seq), 8'(seq + 64), 8'(seq + 128), (i == n - 1), (i < n_exp));
            seq++;
        end
        pix_dval = 1'b0;
        pix_lval = 1'b0;
        step();
        repeat (gap) step();
    endtask

    task automatic start_frame();
        pix_fval = 1'b1;
        sof_next = 1'b1;
        step();
        step();
    endtask

    task automatic end_frame();
        pix_fval = 1'b0;
        repeat (3) step();
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !axis0.tvalid) break;
            step();
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    int b0;
    int e_base;

    initial begin
        rst          = 1'b1;
        pix_data     = '0;
        pix_data2    = 10'h3FF;
        pix_dval     = 1'b0;
        pix_lval     = 1'b0;
        pix_fval     = 1'b0;
        cfg_line_len = 16'd4;
        rdy_level    = 1'b1;
        bp_mode      = 1'b0;
        sof_next     = 1'b0;
        seq          = 0;
        repeat (4) step();

        check("rst_tvalid", 32'(axis0.tvalid), 32'd0);
        check("rst_tkeep", 32'(axis0.tkeep), 32'h7);
        check("rst_tdata", 32'(axis0.tdata), 32'd0);
        check("rst_frame_active", 32'(frame_active0), 32'd0);
        check("rst_frame_count", 32'(frame_count0), 32'd0);
        check("rst_drop_count", 32'(drop_count0), 32'd0);
        check("rst_overflow", 32'(overflow0), 32'd0);
        rst = 1'b0;
        step();

        // basic frame: 3 lines x 4 beats
        start_frame();
        check("frame_active", 32'(frame_active0), 32'd1);
        repeat (3) drive_line(4, 4, 2, 1'b0);
        end_frame();
        wait_drain(50);
        check("basic_frame_count", 32'(frame_count0), 32'd1);
        check("basic_beats", 32'(beats_seen), 32'd12);
        check("basic_err_pulses", 32'(err_pulses), 32'd0);
        check("basic_ovf_pulses", 32'(ovf_pulses), 32'd0);
        check("idle_frame_active", 32'(frame_active0), 32'd0);

        // explicit RGB reorder, single-beat line with length check off
        cfg_line_len = 16'd0;
        start_frame();
        drive_pixel(8'h11, 8'h22, 8'h33, 1'b1, 1'b1);
        pix_dval = 1'b0;
        pix_lval = 1'b0;
        repeat (2) step();
        end_frame();
        wait_drain(50);
        check("reorder_tdata", 32'(last_tdata), 32'h331122);
        check("reorder_no_err", 32'(err_pulses), 32'd0);
        check("reorder_frame_count", 32'(frame_count0), 32'd2);
        cfg_line_len = 16'd4;

        // line-length error: 4 beats then 5 beats (with a dval gap)
        e_base = err_pulses;
        start_frame();
        drive_line(4, 4, 2, 1'b0);
        check("len_ok_line", 32'(err_pulses), 32'(e_base));
        drive_line(5, 5, 2, 1'b1);
        check("len_bad_line", 32'(err_pulses), 32'(e_base + 1));
        end_frame();
        wait_drain(50);
        check("len_err_total", 32'(err_pulses), 32'(e_base + 1));
        check("len_frame_count", 32'(frame_count0), 32'd3);

        // reset in the middle of line 2 with fval held high
        start_frame();
        drive_line(4, 4, 2, 1'b0);
        drive_pixel(8'hA0, 8'hA1, 8'hA2, 1'b0, 1'b0);
        drive_pixel(8'hB0, 8'hB1, 8'hB2, 1'b0, 1'b0);
        rst = 1'b1;
        pix_dval = 1'b0;
        pix_lval = 1'b0;
        step();
        check("midrst_tvalid", 32'(axis0.tvalid), 32'd0);
        repeat (2) step();
        check("midrst_frame_count", 32'(frame_count0), 32'd0);
        rst = 1'b0;
        step();
        drive_line(4, 0, 2, 1'b0);
        check("post_rst_quiet", 32'(axis0.tvalid), 32'd0);
        end_frame();
        check("post_rst_count", 32'(frame_count0), 32'd0);
        start_frame();
        drive_line(4, 4, 2, 1'b0);
        end_frame();
        wait_drain(50);
        check("resync_frame_count", 32'(frame_count0), 32'd1);

        // overflow: stalled sink, 8-beat line into a 4-deep FIFO
        rdy_level = 1'b0;
        repeat (2) step();
        ovf_pulses = 0;
        start_frame();
        drive_line(8, 4, 2, 1'b0);
        end_frame();
        check("ovf_pulses", 32'(ovf_pulses), 32'd1);
        check("ovf_drop_count", 32'(drop_count0), 32'd1);
        check("ovf_frame_count", 32'(frame_count0), 32'd1);
        check("ovf_state_not_active", 32'(frame_active0), 32'd0);
        b0 = beats_seen;
        rdy_level = 1'b1;
        wait_drain(50);
        check("ovf_queued_beats", 32'(beats_seen - b0), 32'd4);
        start_frame();
        drive_line(4, 4, 2, 1'b0);
        end_frame();
        wait_drain(50);
        check("after_ovf_frame_count", 32'(frame_count0), 32'd2);
        check("after_ovf_drop_count", 32'(drop_count0), 32'd1);

        // backpressure: tready toggling every cycle
        b0 = beats_seen;
        bp_mode = 1'b1;
        start_frame();
        repeat (3) drive_line(4, 4, 6, 1'b0);
        end_frame();
        wait_drain(100);
        bp_mode = 1'b0;
        repeat (2) step();
        check("bp_beats", 32'(beats_seen - b0), 32'd12);
        check("bp_ovf_pulses", 32'(ovf_pulses), 32'd1);
        check("bp_frame_count", 32'(frame_count0), 32'd3);
        check("pad_seen", 32'(pad_beats != 0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end
endmodule
